// File: rtl/vt_deletion_decoder_seq.sv
// Sequential VT_a(n) single-deletion decoder: accumulates weight and checksum,
// derives the inserted bit and its position, then rebuilds the codeword.
module vt_deletion_decoder_seq #(
  parameter int MAX_N = 17,
  parameter int CW    = $clog2(MAX_N + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAX_N-1:0] received,
  input  logic [CW-1:0]    n,
  input  logic [CW-1:0]    a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAX_N-1:0] out,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ACCUM, CALC, SCAN, BUILD, DONE} state_t;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW-1:0] NMAX = CW'(MAX_N);

  state_t           state_q, state_d;
  logic [MAX_N-1:0] rcv_q, rcv_d;
  logic [MAX_N-1:0] out_q, out_d;
  logic [CW-1:0]    n_q, n_d;
  logic [CW-1:0]    a_q, a_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    s_q, s_d;
  logic [CW-1:0]    w_q, w_d;
  logic [CW-1:0]    t_q, t_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             b_q, b_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [CW-1:0]    n_m1, np1, idx_m1, pos, pos_m1, d_val, cnt_inc, k_hit;
  logic             y_acc, y_scan, params_bad;
  logic [MAX_N-1:0] x_build;

  assign n_m1    = n_q - ONE;
  assign np1     = n_q + ONE;
  assign idx_m1  = idx_q - ONE;
  assign y_acc   = rcv_q[idx_m1];

  // b=0 sweeps right-to-left counting ones; b=1 sweeps left-to-right counting zeros
  assign pos     = b_q ? idx_q : (n_q - idx_q);
  assign pos_m1  = pos - ONE;
  assign y_scan  = rcv_q[pos_m1];
  assign cnt_inc = cnt_q + {{(CW-1){1'b0}}, (b_q ? ~y_scan : y_scan)};
  assign k_hit   = b_q ? (pos + ONE) : pos;

  // (a - s) mod (n+1); the true result fits in CW bits so wraparound is exact
  assign d_val   = a_q - s_q + ((a_q >= s_q) ? '0 : np1);

  assign params_bad = (n < TWO) || (n > NMAX) || (a > n);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_N; gi++) begin : g_build
      localparam logic [CW-1:0] J = CW'(gi + 1);
      if (gi == 0) begin : g_first
        assign x_build[gi] = (J > n_q) ? 1'b0 :
                             (J < k_q) ? rcv_q[gi] : b_q;
      end else begin : g_rest
        assign x_build[gi] = (J > n_q)  ? 1'b0      :
                             (J < k_q)  ? rcv_q[gi] :
                             (J == k_q) ? b_q       : rcv_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    rcv_d   = rcv_q;
    out_d   = out_q;
    n_d     = n_q;
    a_d     = a_q;
    idx_d   = idx_q;
    s_d     = s_q;
    w_d     = w_q;
    t_d     = t_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    found_d = found_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rcv_d = received;
          n_d   = n;
          a_d   = a;
          idx_d = ONE;
          s_d   = '0;
          w_d   = '0;
          if (params_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            out_d   = '0;
          end else begin
            state_d = ACCUM;
            err_d   = 1'b0;
          end
        end
      end
      ACCUM: begin
        if (y_acc) begin
          w_d = w_q + ONE;
          // s + idx >= n+1  <=>  idx > n - s, avoiding a wider adder
          s_d = (idx_q > (n_q - s_q)) ? (s_q + idx_q - np1) : (s_q + idx_q);
        end
        idx_d = idx_q + ONE;
        if (idx_q == n_m1) state_d = CALC;
      end
      CALC: begin
        if (d_val <= w_q) begin
          b_d     = 1'b0;
          t_d     = d_val;
          k_d     = n_q;
          found_d = (d_val == '0);
        end else begin
          b_d     = 1'b1;
          t_d     = d_val - w_q - ONE;
          k_d     = ONE;
          found_d = ((d_val - w_q - ONE) == '0);
        end
        idx_d   = ONE;
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        cnt_d = cnt_inc;
        if (!found_q && (cnt_inc == t_q)) begin
          k_d     = k_hit;
          found_d = 1'b1;
        end
        idx_d = idx_q + ONE;
        if (idx_q == n_m1) state_d = BUILD;
      end
      BUILD: begin
        out_d   = x_build;
        state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcv_q   <= '0;
      out_q   <= '0;
      n_q     <= '0;
      a_q     <= '0;
      idx_q   <= '0;
      s_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcv_q   <= rcv_d;
      out_q   <= out_d;
      n_q     <= n_d;
      a_q     <= a_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      w_q     <= w_d;
      t_q     <= t_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      found_q <= found_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vt_deletion_decoder_seq.sv
// Directed bench for vt_deletion_decoder_seq: known vectors, parameter sweep,
// backpressure and asynchronous reset during a decode.
module tb_vt_deletion_decoder_seq;
  localparam int MAX_N = 17;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [MAX_N-1:0] received;
  logic [CW-1:0]    n;
  logic [CW-1:0]    a;
  logic             out_valid;
  logic             out_ready;
  logic [MAX_N-1:0] out;
  logic             err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vt_deletion_decoder_seq #(.MAX_N(MAX_N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .received  (received),
    .n         (n),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  function automatic int vt_sum(input logic [MAX_N-1:0] x, input int nn);
    int s;
    s = 0;
    for (int j = 1; j <= nn; j++) if (x[j-1]) s += j;
    return s % (nn + 1);
  endfunction

  function automatic bit del_ok(input logic [MAX_N-1:0] x, input logic [MAX_N-1:0] y, input int nn);
    bit ok;
    for (int p = 1; p <= nn; p++) begin
      ok = 1'b1;
      for (int i = 1; i <= nn - 1; i++) begin
        if (((i < p) ? x[i-1] : x[i]) !== y[i-1]) ok = 1'b0;
      end
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_word(input logic [CW-1:0] nn, input logic [CW-1:0] aa,
                          input logic [MAX_N-1:0] rr, input bit do_ack,
                          output logic [MAX_N-1:0] o, output logic e, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n = nn; a = aa; received = rr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out;
    e = err;
    $display("word n=%0d a=%0d received=%05h out=%05h err=%0d latency=%0d", nn, aa, rr, o, e, lat);
    if (do_ack) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    received = '0; n = '0; a = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (out !== '0) begin failures++; $display("FAIL reset_out got=%05h exp=00000", out); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_vectors();
    logic [MAX_N-1:0] o;
    logic e;
    int lat;
    run_word(5'd4, 5'd0, 17'b0100, 1'b1, o, e, lat);
    checks++;
    if (o !== 17'd9) begin failures++; $display("FAIL n4_out got=%0d exp=9", o); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL n4_err got=%0b exp=0", e); end
    checks++;
    if (lat != 9) begin failures++; $display("FAIL n4_latency got=%0d exp=9", lat); end
    run_word(5'd5, 5'd0, 17'b1111, 1'b1, o, e, lat);
    checks++;
    if (o !== 17'd27) begin failures++; $display("FAIL n5_ones_out got=%0d exp=27", o); end
    checks++;
    if (lat != 11) begin failures++; $display("FAIL n5_ones_latency got=%0d exp=11", lat); end
    run_word(5'd5, 5'd0, 17'b0, 1'b1, o, e, lat);
    checks++;
    if (o !== 17'd0) begin failures++; $display("FAIL n5_zero_out got=%0d exp=0", o); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL n5_zero_err got=%0b exp=0", e); end
    // n below 2 and n above MAX_N are rejected in one cycle
    run_word(5'd1, 5'd0, 17'b1, 1'b1, o, e, lat);
    checks++;
    if (e !== 1'b1 || o !== '0 || lat != 1) begin
      failures++; $display("FAIL n1_reject got err=%0b out=%0d lat=%0d exp err=1 out=0 lat=1", e, o, lat);
    end
    run_word(5'd18, 5'd0, 17'b1, 1'b1, o, e, lat);
    checks++;
    if (e !== 1'b1 || o !== '0 || lat != 1) begin
      failures++; $display("FAIL n18_reject got err=%0b out=%0d lat=%0d exp err=1 out=0 lat=1", e, o, lat);
    end
  endtask

  task automatic test_param_sweep();
    logic [MAX_N-1:0] o;
    logic [MAX_N-1:0] y;
    logic e;
    int lat;
    for (int nn = 3; nn <= 5; nn++) begin
      for (int aa = 1; aa <= 9; aa++) begin
        run_word(CW'(nn), CW'(aa), 17'b0101, 1'b1, o, e, lat);
        if (aa > nn) begin
          checks++;
          if (e !== 1'b1 || o !== '0 || lat != 1) begin
            failures++;
            $display("FAIL sweep_reject n=%0d a=%0d got err=%0b out=%0d lat=%0d exp err=1 out=0 lat=1", nn, aa, e, o, lat);
          end
        end else begin
          y = 17'b0101 & ((17'd1 << (nn - 1)) - 17'd1);
          checks++;
          if (e !== 1'b0 || lat != 2*nn + 1) begin
            failures++;
            $display("FAIL sweep_timing n=%0d a=%0d got err=%0b lat=%0d exp err=0 lat=%0d", nn, aa, e, lat, 2*nn + 1);
          end
          checks++;
          if (vt_sum(o, nn) != aa) begin
            failures++;
            $display("FAIL sweep_checksum n=%0d a=%0d got=%0d exp=%0d out=%05h", nn, aa, vt_sum(o, nn), aa, o);
          end
          checks++;
          if (!del_ok(o, y, nn) || (o >> nn) != '0) begin
            failures++;
            $display("FAIL sweep_deletion n=%0d a=%0d got out=%05h exp a supersequence of %05h within n bits", nn, aa, o, y);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [MAX_N-1:0] o;
    logic e;
    int lat;
    run_word(5'd4, 5'd0, 17'b0100, 1'b0, o, e, lat);
    checks++;
    if (o !== 17'd9) begin failures++; $display("FAIL bp_first_out got=%0d exp=9", o); end
    n = 5'd5; a = 5'd0; received = 17'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out !== 17'd9 || err !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got out=%0d err=%0b valid=%0b in_ready=%0b exp out=9 err=0 valid=1 in_ready=0",
                 c, out, err, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got valid=%0b in_ready=%0b exp valid=0 in_ready=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got in_ready=%0b exp=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("word n=5 a=0 received=00000 out=%05h err=%0d latency=%0d", out, err, lat);
    checks++;
    if (out !== 17'd0 || err !== 1'b0 || lat != 11) begin
      failures++;
      $display("FAIL bp_second got out=%0d err=%0b lat=%0d exp out=0 err=0 lat=11", out, err, lat);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [MAX_N-1:0] o;
    logic e;
    int lat;
    run_word(5'd4, 5'd0, 17'b0100, 1'b1, o, e, lat);
    checks++;
    if (o !== 17'd9) begin failures++; $display("FAIL rm_pre_out got=%0d exp=9", o); end
    @(negedge clk);
    n = 5'd17; a = 5'd5; received = 17'h0A5C3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL rm_async got valid=%0b out=%0d in_ready=%0b err=%0b exp valid=0 out=0 in_ready=1 err=0",
               out_valid, out, in_ready, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_word(5'd5, 5'd0, 17'b1111, 1'b1, o, e, lat);
    checks++;
    if (o !== 17'd27 || e !== 1'b0 || lat != 11) begin
      failures++;
      $display("FAIL rm_fresh got out=%0d err=%0b lat=%0d exp out=27 err=0 lat=11", o, e, lat);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_param_sweep();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vt_deletion_decoder_seq.md
Name: vt_deletion_decoder_seq

Overview:
- Sequential, parametrised successor to the combinational hard decoder.
- Decodes a Varshamov–Tenengolts VT_a(n) codeword that has suffered exactly one deletion.
- The code length n and residue a are selectable per word at runtime, up to MAX_N.
- Sits between the DNA-channel read path and the payload unpacker, with valid/ready handshakes on both sides.

Parameters:
- MAX_N, 17, maximum codeword length n supported; sets the width of received and out.
- CW, $clog2(MAX_N+2), width of the n, a, checksum and counter fields.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  received/n/a are valid.
- in_ready  out  1  block is idle and can accept a word.
- received  in  MAX_N  received word y. y_i = received[i-1] for i = 1..n-1; bits n-1 and above are ignored.
- n  in  CW  codeword length.
- a  in  CW  VT residue, 0..n.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out  out  MAX_N  decoded codeword x. x_j = out[j-1]; bits n and above are 0.
- err  out  1  invalid parameters; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - out = 0, out_valid = 0, err = 0.
  - in_ready = 1 (in_ready is 1 exactly while in IDLE).
  - All internal registers cleared.
  - Reset mid-decode aborts the word; no partial output is ever presented.
- States: IDLE, ACCUM, CALC, SCAN, BUILD, DONE.
- IDLE:
  - On in_valid && in_ready, latch received, n and a.
  - If n < 2, or n > MAX_N, or a > n: go to DONE with err = 1, out = 0. out_valid rises on the next edge.
  - Otherwise go to ACCUM with idx = 1, s = 0, w = 0.
- ACCUM: one bit per cycle for idx = 1..n-1 (n-1 cycles).
  - If y_idx = 1: w += 1, and s = s + idx with one conditional subtraction of (n+1).
  - Invariant: s stays in 0..n.
- CALC (1 cycle):
  - D = (a - s) mod (n+1), computed as a ≥ s ? a - s : a + n + 1 - s.
  - If D ≤ w: b = 0, target T = D.
  - Else: b = 1, target T = D - w - 1.
- SCAN: exactly n-1 cycles, full sweep regardless of where the match is found.
  - b = 0: insert position k = the largest k in 1..n such that ones(y_k..y_{n-1}) = T. For T = 0 this gives k = n (append).
  - b = 1: insert position k = the smallest k such that zeros(y_1..y_{k-1}) = T. For T = 0 this gives k = 1.
  - Record k.
- BUILD (1 cycle):
  - x_j = y_j for j < k; x_k = b; x_j = y_{j-1} for k < j ≤ n; bits above n are 0.
  - Register the result into out.
- DONE:
  - out_valid = 1; out and err are held stable while out_ready = 0.
  - On out_ready: out_valid drops and the FSM returns to IDLE; in_ready = 1 on the following cycle.
  - There is no input/output overlap: one word in flight.
- Latency, valid parameters:
  - out_valid rises 2n+1 rising edges after the accepting edge: (n-1) ACCUM + 1 CALC + (n-1) SCAN + 1 BUILD + 1 register.
  - Worst case MAX_N = 17 gives 35 cycles.
- Latency, invalid parameters: 1 cycle to out_valid.
- in_valid while busy: ignored; the upstream source must hold its data until in_ready.
- Arithmetic: all arithmetic is unsigned. Any k inside a run of equal bits yields an identical x, so the deterministic k rule does not affect correctness.

Test Plan:
- n=4, a=0, received=4'b0100 (y=001, from x=1001 with x_1 deleted):
  - Expect: w=1, s=3, D=2 > w, so b=1, T=0, k=1.
  - Result: out=9 (1001), err=0, out_valid 9 edges after accept.
- n=5, a=0, received=4'b1111 (x=11011 with x_3 deleted):
  - Expect: w=4, s=4, D=2, so b=0, k=3.
  - Result: out=27 (11011), out_valid 11 edges after accept.
- n=5, a=0, received=0:
  - Expect: D=0, append 0 at k=5.
  - Result: out=0, err=0.
- Parameter sweep, n=3..5 with a = 1..9 (including a > n) on received=4'b0101:
  - a > n gives err=1, out=0 after 1 cycle.
  - Every accepted word yields out such that (sum of j·x_j) mod (n+1) = a and deleting some bit of out gives received.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with a new in_valid asserted: out and err stable, in_ready=0.
  - Release out_ready: one-cycle handshake, then in_ready=1 and the next word is accepted.
- Reset mid-operation:
  - Assert rst_n=0 during SCAN: out_valid=0, out=0, in_ready=1 immediately (asynchronous).
  - A fresh word after release decodes correctly with nominal latency.
